alu_seq_multiplier: RTL



---
 rtl/alu_seq_multiplier_pkg.sv | 15 +
 rtl/alu_seq_multiplier_add.sv | 14 +
 rtl/alu_seq_multiplier.sv | 121 ++++++++++++
 3 files changed

// File: rtl/alu_seq_multiplier_pkg.sv
// Shared ALU definitions: operand width, multiplier FSM encodings and iteration count.
// Imported by the sequential multiplier and its adder.
package alu_seq_multiplier_pkg;

   localparam int WIDTH     = 32;
   localparam int MUL_ITERS = WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } mulState_t;

endpackage

// File: rtl/alu_seq_multiplier_add.sv
// Plain N-bit adder with carry-in; the multiplier instantiates it once at WIDTH+1 bits for the
// accumulate step and once at 2*WIDTH bits for the final two's-complement negation.
module AluAdd33 #(
   parameter int N = 33
)(
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum
);

   assign sum = a + b + N'(cin);

endmodule

// File: rtl/alu_seq_multiplier.sv
// Radix-2 shift-add 32x32 multiplier with a start/busy/done handshake. Signed products are
// formed from operand magnitudes and a sign flag that negates the 64-bit result in FIX.
module alu_seq_multiplier #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   import alu_seq_multiplier_pkg::*;

   localparam int PW = 2 * WIDTH;

   mulState_t        state;
   mulState_t        stateNext;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [PW-1:0]    accum;
   logic             negFlag;
   logic [CNT_W-1:0] iterCnt;

   logic [WIDTH-1:0] absA;
   logic [WIDTH-1:0] absB;
   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   stepSum;
   logic [PW-1:0]    negAccum;
   logic [PW-1:0]    fixedAccum;
   logic             lastIter;

   // 0x8000_0000 maps onto itself, which is exactly its unsigned magnitude
   assign absA   = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
   assign absB   = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
   assign addend = mplier[0] ? mcand : '0;
   assign lastIter   = (iterCnt == CNT_W'(WIDTH - 1));
   assign fixedAccum = negFlag ? negAccum : accum;

   AluAdd33 #(.N(WIDTH + 1)) stepAdder (
      .a   ({1'b0, accum[PW-1:WIDTH]}),
      .b   ({1'b0, addend}),
      .cin (1'b0),
      .sum (stepSum)
   );

   AluAdd33 #(.N(PW)) negAdder (
      .a   (~accum),
      .b   ('0),
      .cin (1'b1),
      .sum (negAccum)
   );

   // State register; reset wins over everything else
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic; start is only honoured when no multiply is in flight
   always_comb begin
      stateNext = state;
      case (state)
         S_IDLE:  if (start) stateNext = S_RUN;
         S_RUN:   if (lastIter) stateNext = S_FIX;
         S_FIX:   stateNext = S_DONE;
         S_DONE:  stateNext = start ? S_RUN : S_IDLE;
         default: stateNext = S_IDLE;
      endcase
   end

   // Datapath and registered handshake outputs; busy/done are derived from the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand   <= '0;
         mplier  <= '0;
         accum   <= '0;
         negFlag <= 1'b0;
         iterCnt <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         lo      <= '0;
         hi      <= '0;
      end else begin
         busy <= (stateNext == S_RUN) || (stateNext == S_FIX);
         done <= (stateNext == S_DONE);
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  mcand   <= absA;
                  mplier  <= absB;
                  negFlag <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  accum   <= '0;
                  iterCnt <= '0;
               end
            end
            S_RUN: begin
               accum   <= {stepSum, accum[WIDTH-1:1]};
               mplier  <= mplier >> 1;
               iterCnt <= iterCnt + CNT_W'(1);
            end
            S_FIX: begin
               accum <= fixedAccum;
               lo    <= fixedAccum[WIDTH-1:0];
               hi    <= fixedAccum[PW-1:WIDTH];
            end
            default: ;
         endcase
      end
   end

endmodule
